lif_neuron: RTL

Clocked leaky integrate-and-fire neuron, parametrised in input count, weight width and potential width. Replaces the stateless threshold-sum neuron: it keeps a membrane potential across time steps, fires a one-cycle spike on a threshold crossing, then enters a refractory period. One instance per output neuron in a layer. Time steps are driven by a shared `step_valid` strobe.

---
 rtl/lif_neuron_if.sv | 25 ++
 rtl/lif_neuron.sv | 116 +++++++++++
 2 files changed

// File: rtl/lif_neuron_if.sv
// Time-step bus between a layer controller and one lif_neuron: step strobe, flush,
// presynaptic spikes, weights in; spike, membrane potential, refractory flag out.
interface lif_neuron_if #(
  parameter int NUM_INPUTS = 16,
  parameter int WBITS      = 4,
  parameter int POT_BITS   = 10
);
  logic                                 step_valid;
  logic                                 clear;
  logic [NUM_INPUTS-1:0]                spikes_in;
  logic [NUM_INPUTS-1:0][WBITS-1:0]     weights;
  logic                                 spike_out;
  logic [POT_BITS-1:0]                  potential;
  logic                                 refractory;

  modport master (
    output step_valid, clear, spikes_in, weights,
    input  spike_out, potential, refractory
  );

  modport slave (
    input  step_valid, clear, spikes_in, weights,
    output spike_out, potential, refractory
  );
endinterface

// File: rtl/lif_neuron.sv
// Clocked leaky integrate-and-fire neuron with saturating potential and refractory period.
// Define LIF_NEURON_LEAK_EN to compile in the v - (v >> LEAK_SHIFT) leak; otherwise a pure integrator.
module lif_neuron #(
  parameter int NUM_INPUTS   = 16,
  parameter int WBITS        = 4,
  parameter int POT_BITS     = 10,
  parameter int THRESHOLD    = 20,
  parameter int REFRAC_STEPS = 2,
  parameter int LEAK_SHIFT   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  lif_neuron_if.slave  bus
);

  localparam int SUM_BITS = WBITS + $clog2(NUM_INPUTS + 1);
  localparam int ADD_BITS = ((POT_BITS > SUM_BITS) ? POT_BITS : SUM_BITS) + 1;
  localparam int RC_BITS  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic [POT_BITS-1:0] POT_MAX = '1;
  localparam logic [31:0]         THR     = THRESHOLD;
  localparam logic [RC_BITS-1:0]  RC_INIT = RC_BITS'(REFRAC_STEPS);
  localparam logic [RC_BITS-1:0]  RC_ONE  = RC_BITS'(1);

`ifdef LIF_NEURON_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [RC_BITS-1:0]  rc_q, rc_d;
  logic [POT_BITS-1:0] v_q, v_d;
  logic                spike_q, spike_d;

  logic [SUM_BITS-1:0] sum;
  logic [POT_BITS-1:0] v_l;
  logic [ADD_BITS-1:0] v_sum;
  logic [POT_BITS-1:0] v_n;
  logic                fire;

  // NOTE: blocking '=' is correct here because this is combinational accumulation
  // within one evaluation; registered state below uses '<=' only.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bus.spikes_in[i]) sum = sum + SUM_BITS'(bus.weights[i]);
    end
  end

  always_comb begin
    v_l   = LEAK_ON ? (v_q - (v_q >> LEAK_SHIFT)) : v_q;
    v_sum = ADD_BITS'(v_l) + ADD_BITS'(sum);
    // Anything above the potential width saturates to the top code.
    v_n   = (|v_sum[ADD_BITS-1:POT_BITS]) ? POT_MAX : v_sum[POT_BITS-1:0];
    fire  = 32'(v_n) > THR;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    v_d     = v_q;
    spike_d = 1'b0;
    if (bus.clear) begin
      state_d = INTEGRATE;
      rc_d    = '0;
      v_d     = '0;
    end else if (bus.step_valid) begin
      unique case (state_q)
        INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = '0;
            rc_d    = RC_INIT;
            state_d = (REFRAC_STEPS > 0) ? REFRACTORY : INTEGRATE;
          end else begin
            v_d = v_n;
          end
        end
        REFRACTORY: begin
          // The step that leaves refractory does not integrate.
          v_d  = '0;
          rc_d = rc_q - RC_ONE;
          if (rc_q == RC_ONE) state_d = INTEGRATE;
        end
      endcase
    end
  end

  // NOTE: only control/state registers exist here, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INTEGRATE;
      rc_q    <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign bus.spike_out  = spike_q;
  assign bus.potential  = v_q;
  assign bus.refractory = (state_q == REFRACTORY);

endmodule
